// File: rtl/vect2bits_pulse_pkg.sv
// Shared constants for the tProc word splitter: field offsets and mode encodings.
package vect2bits_pulse_pkg;

  // The value field starts at bit 0. The write-enable field starts at bit N, so it
  // depends on the instance parameter and is derived in the top level.
  localparam int unsigned VAL_LSB = 0;

  // Per-bit mode encodings, as they appear on the mode input.
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  // Offset of the write-enable mask for an N-bit splitter.
  function automatic int unsigned we_lsb(input int unsigned n);
    return n;
  endfunction

endpackage

// File: rtl/vect2bits_pulse_ch.sv
// One output channel: latched mode, pulse down-counter, output bit and busy flag.
module vect2bits_pulse_ch
  import vect2bits_pulse_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             we_i,
  input  logic             val_i,
  input  logic             mode_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             dout_o,
  output logic             busy_o,
  output logic             mode_o
);

  logic             mode_q, mode_d;
  logic [LEN_W-1:0] cnt_q,  cnt_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;

  // Next state. A write always wins over a pulse expiring in the same cycle.
  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    busy_d = busy_q;
    if (we_i) begin
      mode_d = mode_i;
      if (mode_i == MODE_PULSE && val_i) begin
        // Start or extend a pulse. A length of 0 behaves like a length of 1.
        dout_d = 1'b1;
        busy_d = 1'b1;
        cnt_d  = (len_i == '0) ? '0 : len_i - 1'b1;
      end else begin
        // A level write, or a pulse write of 0, sets the bit and aborts any pulse.
        dout_d = val_i;
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (busy_q && mode_q == MODE_PULSE) begin
      if (cnt_q == '0) begin
        dout_d = 1'b0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // State register. Reset clears everything and leaves the channel in level mode.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q <= MODE_LEVEL;
      cnt_q  <= '0;
      dout_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
    end
  end

  assign dout_o = dout_q;
  assign busy_o = busy_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/vect2bits_pulse.sv
// Splits a tProc output word into N trigger/marker bits, each in level or pulse mode.
//
// Input strobe: din_valid is a valid-only strobe with no ready. A word is taken on
// every rising clk edge where din_valid is high. Each bit whose write-enable is set
// updates on that edge, and dout/busy show the result from then on.
module vect2bits_pulse
  import vect2bits_pulse_pkg::*;
#(
  parameter int unsigned DIN_W = 160,
  parameter int unsigned N     = 16,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  input  logic [N-1:0]     mode,
  input  logic [LEN_W-1:0] pulse_len,
  output logic [N-1:0]     dout,
  output logic [N-1:0]     busy
);

  localparam int unsigned WE_LSB = we_lsb(N);

  // Elaboration-time parameter checks.
  if (DIN_W < 2 * N) begin : g_din_w_check
    $error("vect2bits_pulse: DIN_W (%0d) must be >= 2*N (%0d)", DIN_W, 2 * N);
  end
  if (N < 1 || N > 64) begin : g_n_check
    $error("vect2bits_pulse: N (%0d) must be within 1..64", N);
  end

  logic [N-1:0] val;
  logic [N-1:0] we;
  logic [N-1:0] mode_latched;

  assign val = din[VAL_LSB +: N];
  assign we  = din_valid ? din[WE_LSB +: N] : '0;

  // The bits above the two fields carry nothing for this block.
  if (DIN_W > 2 * N) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^din[DIN_W-1:2*N];
  end

  // The latched modes are kept per channel and are visible here for debug.
  logic unused_mode_latched;
  assign unused_mode_latched = ^mode_latched;

  for (genvar i = 0; i < N; i++) begin : g_ch
    vect2bits_pulse_ch #(
      .LEN_W (LEN_W)
    ) u_ch (
      .clk     (clk),
      .aresetn (aresetn),
      .we_i    (we[i]),
      .val_i   (val[i]),
      .mode_i  (mode[i]),
      .len_i   (pulse_len),
      .dout_o  (dout[i]),
      .busy_o  (busy[i]),
      .mode_o  (mode_latched[i])
    );
  end

endmodule

// File: tb/tb_vect2bits_pulse.sv
// Directed testbench for vect2bits_pulse with N = 16.
module tb_vect2bits_pulse;

  localparam int unsigned DIN_W = 160;
  localparam int unsigned N     = 16;
  localparam int unsigned LEN_W = 16;

  logic             clk;
  logic             aresetn;
  logic [DIN_W-1:0] din;
  logic             din_valid;
  logic [N-1:0]     mode;
  logic [LEN_W-1:0] pulse_len;
  logic [N-1:0]     dout;
  logic [N-1:0]     busy;

  int tests_run = 0;
  int tests_failed = 0;

  vect2bits_pulse #(
    .DIN_W (DIN_W),
    .N     (N),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .din       (din),
    .din_valid (din_valid),
    .mode      (mode),
    .pulse_len (pulse_len),
    .dout      (dout),
    .busy      (busy)
  );

  // Clock and time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout tests_run=%0d limit=200000ns", tests_run);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single edge.
  task automatic wr(input logic [15:0] val, input logic [15:0] we,
                    input logic [15:0] md, input logic [15:0] len);
    din         = '0;
    din[15:0]   = val;
    din[31:16]  = we;
    mode        = md;
    pulse_len   = len;
    din_valid   = 1'b1;
    tick();
    din_valid   = 1'b0;
  endtask

  logic [15:0] exp_dout;
  logic [15:0] exp_busy;

  initial begin
    // Reset is held while the word tries to write and pulse every bit.
    aresetn   = 1'b0;
    din       = '0;
    din[31:0] = 32'hFFFF_FFFF;
    din_valid = 1'b1;
    mode      = 16'hFFFF;
    pulse_len = 16'd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("reset_dout", 64'(dout), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
    end
    din_valid = 1'b0;
    din       = '0;
    aresetn   = 1'b1;
    tick();
    chk("post_reset_dout", 64'(dout), 64'h0);

    // Level writes.
    wr(16'h00A5, 16'hFFFF, 16'h0000, 16'd0);
    chk("level_dout", 64'(dout), 64'h00A5);
    chk("level_busy", 64'(busy), 64'h0);
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("level_hold", 64'(dout), 64'h00A5);
    end
    wr(16'h0000, 16'h0001, 16'h0000, 16'd0);
    chk("level_clear_bit0", 64'(dout), 64'h00A4);
    wr(16'h0000, 16'hFFFF, 16'h0000, 16'd0);
    chk("level_clear_all", 64'(dout), 64'h0);

    // Pulse of length 4 on bit 3.
    wr(16'h0008, 16'h0008, 16'h0008, 16'd4);
    for (int k = 0; k < 6; k++) begin
      chk("pulse4_dout", 64'(dout), (k < 4) ? 64'h0008 : 64'h0);
      chk("pulse4_busy", 64'(busy), (k < 4) ? 64'h0008 : 64'h0);
      tick();
    end

    // A length of 0 gives a single-cycle pulse.
    wr(16'h0008, 16'h0008, 16'h0008, 16'd0);
    for (int k = 0; k < 3; k++) begin
      chk("pulse0_dout", 64'(dout), (k < 1) ? 64'h0008 : 64'h0);
      chk("pulse0_busy", 64'(busy), (k < 1) ? 64'h0008 : 64'h0);
      tick();
    end

    // Retrigger bit 2 six cycles after the first write, length 10.
    wr(16'h0004, 16'h0004, 16'h0004, 16'd10);
    for (int c = 1; c <= 16; c++) begin
      chk("retrig_dout", 64'(dout), 64'h0004);
      chk("retrig_busy", 64'(busy), 64'h0004);
      if (c == 6) begin
        din        = '0;
        din[15:0]  = 16'h0004;
        din[31:16] = 16'h0004;
        mode       = 16'h0004;
        pulse_len  = 16'd10;
        din_valid  = 1'b1;
      end
      tick();
      din_valid = 1'b0;
    end
    chk("retrig_end_dout", 64'(dout), 64'h0);
    chk("retrig_end_busy", 64'(busy), 64'h0);

    // A level write of 1 three cycles into a long pulse keeps the bit high and idle.
    wr(16'h0020, 16'h0020, 16'h0020, 16'd50);
    chk("abort_start_busy", 64'(busy), 64'h0020);
    tick();
    tick();
    wr(16'h0020, 16'h0020, 16'h0000, 16'd50);
    chk("abort_level_dout", 64'(dout), 64'h0020);
    chk("abort_level_busy", 64'(busy), 64'h0);
    for (int k = 0; k < 60; k++) tick();
    chk("abort_level_hold_dout", 64'(dout), 64'h0020);
    chk("abort_level_hold_busy", 64'(busy), 64'h0);
    wr(16'h0000, 16'h0020, 16'h0000, 16'd0);
    chk("abort_level_clear", 64'(dout), 64'h0);

    // A pulse write of 0 three cycles into a long pulse ends it on the next edge.
    wr(16'h0020, 16'h0020, 16'h0020, 16'd50);
    tick();
    tick();
    wr(16'h0000, 16'h0020, 16'h0020, 16'd50);
    chk("abort_pulse_dout", 64'(dout), 64'h0);
    chk("abort_pulse_busy", 64'(busy), 64'h0);
    tick();
    chk("abort_pulse_after", 64'(dout), 64'h0);

    // Independent channels: bit 15 for 7 cycles and a level 1 on bit 8, then bit 0
    // for 3 cycles one cycle later.
    wr(16'h8100, 16'h8100, 16'h8000, 16'd7);
    for (int k = 1; k <= 9; k++) begin
      exp_dout = 16'h0100;
      exp_busy = 16'h0000;
      if (k <= 7) begin
        exp_dout = exp_dout | 16'h8000;
        exp_busy = exp_busy | 16'h8000;
      end
      if (k >= 2 && k <= 4) begin
        exp_dout = exp_dout | 16'h0001;
        exp_busy = exp_busy | 16'h0001;
      end
      chk("indep_dout", 64'(dout), 64'(exp_dout));
      chk("indep_busy", 64'(busy), 64'(exp_busy));
      if (k == 1) begin
        din        = '0;
        din[15:0]  = 16'h0001;
        din[31:16] = 16'h0001;
        mode       = 16'h0001;
        pulse_len  = 16'd3;
        din_valid  = 1'b1;
      end
      tick();
      din_valid = 1'b0;
    end

    // Reset in the middle of a pulse clears immediately and nothing comes back.
    wr(16'h8000, 16'h8000, 16'h8000, 16'd7);
    tick();
    chk("midpulse_before", 64'(dout), 64'h8100);
    #2;
    aresetn = 1'b0;
    #1;
    chk("midpulse_async_dout", 64'(dout), 64'h0);
    chk("midpulse_async_busy", 64'(busy), 64'h0);
    tick();
    aresetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("after_release_dout", 64'(dout), 64'h0);
      chk("after_release_busy", 64'(busy), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
